dir_mem_bank: RTL
=================

# dir_mem_bank

Parametrised, latency-modelled backing memory for the directory coherence model. It serves line-fill reads and accepts cache write-backs through a request/response handshake, with a programmable access latency and a reset-loaded initial image. The block sits below the directory controller as the single home memory. It replaces the fixed 8-entry, write-back-only store with an addressable read/write block.

## Interface
Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries.
- LATENCY, 2, access cycles between acceptance and response; legal range 1..15.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_req  in  1  read request, level; sampled only in IDLE.
- rd_addr  in  ADDR_W  read address; latched on acceptance.
- rd_valid  out  1  one-cycle pulse; rd_data is valid in that cycle.
- rd_data  out  DATA_W  read data; holds its last value between pulses.
- rd_err  out  1  parity error flag, qualified by rd_valid.
- dataWB_enable  in  1  write-back request, level; sampled only in IDLE.
- dataWB_addr  in  ADDR_W  write-back address; latched on acceptance.
- dataWB_data  in  DATA_W  write-back data; latched on acceptance.
- dataWB_ack  out  1  one-cycle pulse; the write has been committed.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states:
  - IDLE:
    - dataWB_enable high → WB_WAIT.
    - Otherwise rd_req high → RD_WAIT.
    - Neither → stay in IDLE.
  - RD_WAIT and WB_WAIT: count LATENCY cycles, then → RESP.
  - RESP: lasts one cycle, then → IDLE.
- Simultaneous rd_req and dataWB_enable in IDLE: the write-back wins. The read stays pending, because the requester keeps rd_req high, and is accepted on a later IDLE cycle. It therefore returns the freshly written data.
- On acceptance, the block latches the address, the op type and the write data, and loads the counter with LATENCY-1.
- Read: the array is read at the edge entering RESP. rd_data and rd_err are updated, and rd_valid = 1 during RESP.
- Write-back: the array entry is written at the edge entering RESP, and dataWB_ack = 1 during RESP.
- Requests are ignored outside IDLE; there is no queueing. A requester drops its request after seeing its pulse. A request still high in the IDLE cycle after RESP is a new access.
- Reset:
  - Outputs: busy, rd_valid, dataWB_ack, rd_err = 0; rd_data = 0; state = IDLE.
  - Array reloaded with the init image: entries 0..7 = 10, 8, 10, 18, 20, 28, 68, 96 decimal.
  - Entries ≥ 8 are set to 0. Entries of the image beyond DEPTH are dropped.
- Reset mid-operation: the access is aborted, a pending write is discarded, and no pulse is emitted.
- Width rules: the init image values are truncated or zero-extended to DATA_W.

## Timing
- A request sampled high at edge N in IDLE puts the block in RESP from edge N+LATENCY until edge N+LATENCY+1.
- busy is high from edge N+1 through the RESP cycle.
- The response pulse appears LATENCY cycles after the acceptance edge.
- Back-to-back throughput is one access per LATENCY+2 cycles. This counts the accepting IDLE cycle, LATENCY wait cycles and the RESP cycle.
- LATENCY=1: a single wait cycle, then RESP.

## Configuration
- MEM_PARITY_EN defined:
  - Each entry stores DATA_W+1 bits, with the extra top bit holding even parity over the data.
  - Parity is generated on writes and on the reset load.
  - On reads, rd_err = 1 during RESP when the stored parity mismatches.
  - A bench-only hierarchical hook may corrupt an entry to exercise this.
- MEM_PARITY_EN undefined: entries are DATA_W bits and rd_err is tied to 0.

## Structure
- Package dir_mem_pkg holds:
  - the default DATA_W and ADDR_W;
  - the state enum typedef;
  - the INIT_IMAGE constant array of 8 words;
  - an even-parity function.
- Sub-module dir_mem_array: a register array with synchronous reset-load of the image, one write port and one read port. The FSM and counter stay in dir_mem_bank.

## Test plan
- Reset with LATENCY=2, then rd_req at addr 6 → rd_valid 2 cycles after acceptance, rd_data=68, busy high for 3 cycles.
- Write-back addr 3, data 0x00AA, then read addr 3 → dataWB_ack pulse once; read returns 0x00AA.
- rd_req and dataWB_enable high together, same addr 1, data 0x0055 → write is served first, and the following read returns 0x0055 rather than 8.
- Reset asserted during WB_WAIT for addr 0 → no ack; a subsequent read of addr 0 returns 10.
- LATENCY=1 and LATENCY=15 sweeps, read addr 7 → pulse at exactly 1 and 15 cycles respectively, data 96.
- With MEM_PARITY_EN, flip bit 0 of entry 2 and read it → rd_err=1 with rd_valid; reads of other entries keep rd_err=0.

Source files
------------

// File: rtl/dir_mem_pkg.sv
// Shared definitions for the directory home-memory bank: default widths,
// FSM state encoding, the reset-time memory image and an even-parity helper.
// Optional feature macro used by the bank: MEM_PARITY_EN.
package dir_mem_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 3;
   localparam int INIT_LEN   = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WB_WAIT = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam int INIT_IMAGE [INIT_LEN] = '{10, 8, 10, 18, 20, 28, 68, 96};

   // Zero-extending a word leaves its parity unchanged, so one wide helper
   // serves every data width up to 64 bits.
   function automatic logic even_parity(input logic [63:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/dir_mem_array.sv
// Register array behind the home-memory bank: synchronous reset reloads the
// init image, one write port, one asynchronous read port.
// With MEM_PARITY_EN defined each entry carries an extra even-parity bit on
// top of the data and the read port reports a parity mismatch.
module dir_mem_array
   import dir_mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
`ifdef MEM_PARITY_EN
   output logic              rd_perr,
`endif
   output logic [DATA_W-1:0] rd_word
);

   localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEM_PARITY_EN
   localparam int ENTRY_W = DATA_W + 1;
`else
   localparam int ENTRY_W = DATA_W;
`endif

   logic [ENTRY_W-1:0] mem [DEPTH];

   // Builds the stored form of a data word (data plus parity when enabled).
   function automatic logic [ENTRY_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef MEM_PARITY_EN
      return {even_parity(64'(d)), d};
`else
      return d;
`endif
   endfunction

   // Image word for an entry; entries past the image are zero and image
   // values are truncated or zero-extended to the data width.
   function automatic logic [DATA_W-1:0] image_word(input int idx);
      logic [31:0] raw;
      raw = (idx < INIT_LEN) ? 32'(INIT_IMAGE[idx % INIT_LEN]) : 32'd0;
      return DATA_W'(raw);
   endfunction

   // Reset reloads the whole image; otherwise commit the single write port.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= encode(image_word(i));
         end
      end else if (wr_en) begin
         mem[wr_addr] <= encode(wr_data);
      end
   end

   assign rd_word = mem[rd_addr][DATA_W-1:0];

`ifdef MEM_PARITY_EN
   assign rd_perr = mem[rd_addr][DATA_W] != even_parity(64'(rd_word));
`endif

endmodule

// File: rtl/dir_mem_bank.sv
// Latency-modelled home memory for the directory coherence model. Serves
// line-fill reads and write-backs one at a time; write-back wins when both
// requests arrive together. Optional macro: MEM_PARITY_EN (parity per entry,
// rd_err reports mismatches; otherwise rd_err is tied low).
module dir_mem_bank
   import dir_mem_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int LATENCY = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_err,
   input  logic              dataWB_enable,
   input  logic [ADDR_W-1:0] dataWB_addr,
   input  logic [DATA_W-1:0] dataWB_data,
   output logic              dataWB_ack,
   output logic              busy
);

   localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

   state_t             state;
   state_t             next_state;
   logic [3:0]         count;
   logic [ADDR_W-1:0]  op_addr;
   logic [DATA_W-1:0]  op_data;
   logic               op_rd;
   logic               count_done;
   logic               wr_en;
   logic [DATA_W-1:0]  arr_word;

   assign count_done = (count == 4'd0);
   assign wr_en      = (state == WB_WAIT) && count_done;

`ifdef MEM_PARITY_EN
   logic arr_perr;
   logic rd_err_q;
`endif

   dir_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (op_addr),
      .wr_data (op_data),
      .rd_addr (op_addr),
`ifdef MEM_PARITY_EN
      .rd_perr (arr_perr),
`endif
      .rd_word (arr_word)
   );

   // State register; reset aborts any access in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: write-back has priority, waits run until the counter empties.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (dataWB_enable) begin
               next_state = WB_WAIT;
            end else if (rd_req) begin
               next_state = RD_WAIT;
            end
         end
         RD_WAIT, WB_WAIT: begin
            if (count_done) begin
               next_state = RESP;
            end
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Latch the accepted request and run the latency counter down while waiting.
   always_ff @(posedge clock) begin
      if (reset) begin
         count   <= 4'd0;
         op_addr <= '0;
         op_data <= '0;
         op_rd   <= 1'b0;
      end else if (state == IDLE) begin
         if (dataWB_enable) begin
            op_addr <= dataWB_addr;
            op_data <= dataWB_data;
            op_rd   <= 1'b0;
            count   <= COUNT_LOAD;
         end else if (rd_req) begin
            op_addr <= rd_addr;
            op_rd   <= 1'b1;
            count   <= COUNT_LOAD;
         end
      end else if ((state == RD_WAIT || state == WB_WAIT) && !count_done) begin
         count <= count - 4'd1;
      end
   end

   // Read data is captured on the edge entering RESP and held until the next read.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_data <= '0;
`ifdef MEM_PARITY_EN
         rd_err_q <= 1'b0;
`endif
      end else if (state == RD_WAIT && count_done) begin
         rd_data <= arr_word;
`ifdef MEM_PARITY_EN
         rd_err_q <= arr_perr;
`endif
      end
   end

   assign busy       = (state != IDLE);
   assign rd_valid   = (state == RESP) && op_rd;
   assign dataWB_ack = (state == RESP) && !op_rd;

`ifdef MEM_PARITY_EN
   assign rd_err = rd_valid && rd_err_q;
`else
   assign rd_err = 1'b0;
`endif

endmodule
